eve_gene_compactor: RTL

Downstream stage of the EvE delete-gene engine. Consumes the gene stream produced there and discards every gene whose valid byte is 8'hFF, which marks a deleted node, a deleted connection or a dangling connection. Surviving genes are packed into a DEPTH-entry FIFO with valid/ready output handshake. At the end of each genome, one trailer word carrying the per-genome node, connection and drop counts is appended.

---
 rtl/eve_gene_compactor_if.sv | 22 ++
 rtl/eve_gene_compactor.sv | 138 +++++++++++++
 2 files changed

// File: rtl/eve_gene_compactor_if.sv
// Stream bundle between the delete-gene engine, the compactor and its consumer.
// The slave modport is the compactor's view of the bundle; the master modport is the environment's view.
interface eve_gene_compactor_if;
    logic [63:0] InGene;
    logic        InValid;
    logic        InLast;
    logic        InReady;
    logic [63:0] OutGene;
    logic        OutLast;
    logic        OutValid;
    logic        OutReady;

    modport master (
        output InGene, InValid, InLast, OutReady,
        input  InReady, OutGene, OutLast, OutValid
    );

    modport slave (
        input  InGene, InValid, InLast, OutReady,
        output InReady, OutGene, OutLast, OutValid
    );
endinterface

// File: rtl/eve_gene_compactor.sv
// Drops genes whose valid byte is 8'hFF, packs the survivors into a FIFO and
// appends one count trailer per genome.
module eve_gene_compactor #(
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        Reset,
    eve_gene_compactor_if.slave         bus,
    output logic [15:0]                 NodeCount,
    output logic [15:0]                 ConnCount,
    output logic [15:0]                 DropCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic {
        ST_STREAM  = 1'b0,
        ST_TRAILER = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [64:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] occ_q, occ_d;
    logic [15:0]   node_q, node_d;
    logic [15:0]   conn_q, conn_d;
    logic [15:0]   drop_q, drop_d;
    logic          ready_en_q;

    logic          in_ready;
    logic          out_valid;
    logic          accept;
    logic          pop;
    logic          gene_dropped;
    logic          gene_push;
    logic          trailer_wr;
    logic          push;
    logic [64:0]   wr_data;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ready_en_q holds InReady low through reset and opens it at the first edge after release.
    assign in_ready     = ready_en_q && (state_q == ST_STREAM) && (occ_q < DEPTH_P);
    assign out_valid    = (occ_q != '0);
    assign accept       = bus.InValid & in_ready;
    assign pop          = out_valid & bus.OutReady;
    assign gene_dropped = (bus.InGene[63:56] == 8'hFF);
    assign gene_push    = accept & ~gene_dropped;
    assign trailer_wr   = (state_q == ST_TRAILER) && (occ_q < DEPTH_P);
    assign push         = gene_push | trailer_wr;

    assign wr_data = trailer_wr ? {1'b1, 8'hFE, 8'h00, node_q, conn_q, drop_q}
                                : {1'b0, bus.InGene};

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid;
    assign bus.OutGene  = mem_q[rd_ptr_q[AW-1:0]][63:0];
    assign bus.OutLast  = mem_q[rd_ptr_q[AW-1:0]][64];

    assign NodeCount = node_q;
    assign ConnCount = conn_q;
    assign DropCount = drop_q;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STREAM:  if (accept && bus.InLast) state_d = ST_TRAILER;
            ST_TRAILER: if (trailer_wr)           state_d = ST_STREAM;
            default:                              state_d = ST_STREAM;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        occ_d    = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + PW'(1);
            2'b01:   occ_d = occ_q - PW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // The trailer snapshots the counters on the same edge that clears them.
    always_comb begin
        node_d = node_q;
        conn_d = conn_q;
        drop_d = drop_q;
        if (trailer_wr) begin
            node_d = '0;
            conn_d = '0;
            drop_d = '0;
        end else if (accept) begin
            if (gene_dropped)         drop_d = sat_inc(drop_q);
            else if (bus.InGene[55])  conn_d = sat_inc(conn_q);
            else                      node_d = sat_inc(node_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_STREAM;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            node_q     <= '0;
            conn_q     <= '0;
            drop_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            node_q     <= node_d;
            conn_q     <= conn_d;
            drop_q     <= drop_d;
            ready_en_q <= 1'b1;
        end
    end

    // NOTE: the storage is reset because OutGene/OutLast are read straight from it and must be 0 after reset.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule
